// File: rtl/idma_resi_pkg.sv
// Shared types and width helpers for the residual-mode read address generator.
package idma_resi_pkg;

  typedef enum logic {
    RESI_IDLE = 1'b0,
    RESI_RUN  = 1'b1
  } resi_state_e;

  localparam int unsigned RESI_MAX_SRC = 8;

  function automatic int unsigned resiIdxW(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/idma_resi_src_ptr.sv
// Per-source address pointer: loads its base at start, advances by the stride
// on each accepted beat of its source, and clears when a sequence ends.
module idma_resi_src_ptr #(
  parameter int ADDR_W = 32,
  parameter int GAP_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_inc,
  input  logic [GAP_W-1:0]  i_gap,
  input  logic              i_clear,
  output logic [ADDR_W-1:0] o_ptr
);

  logic [ADDR_W-1:0] r_ptr;

  // Clearing wins over load and increment so an ending sequence leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_clear) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_base;
    end else if (i_inc) begin
      r_ptr <= r_ptr + ADDR_W'(i_gap);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/idma_rd_sync_resi_raddr_gen_nsrc.sv
// Residual-mode read address generator: interleaves one address per active
// source per iteration into the read address FIFO, with abort and done pulse.
module idma_rd_sync_resi_raddr_gen_nsrc
  import idma_resi_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int ADDR_W  = 32,
  parameter int GAP_W   = 16,
  parameter int LOOP_W  = 16,
  localparam int SRC_W  = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_resi_mode,
  input  logic [SRC_W:0]            cfg_src_num,
  input  logic [NUM_SRC*ADDR_W-1:0] cfg_base_addr,
  input  logic [GAP_W-1:0]          cfg_addr_gap,
  input  logic [LOOP_W-1:0]         cfg_loop_num,
  input  logic [GAP_W-1:0]          cfg_last_adj,
  input  logic                      rd_req,
  input  logic                      rd_abort,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [SRC_W-1:0]          out_src_id,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned N_SRC = (NUM_SRC > RESI_MAX_SRC) ? RESI_MAX_SRC : NUM_SRC;

  resi_state_e       r_state;
  resi_state_e       w_nextState;
  logic [SRC_W:0]    r_srcNum;
  logic [SRC_W:0]    w_srcNumClamp;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  r_lastAdj;
  logic [LOOP_W-1:0] r_loopNum;
  logic [LOOP_W-1:0] r_iter;
  logic [SRC_W-1:0]  r_srcIdx;
  logic              r_done;
  logic              w_start;
  logic              w_zeroStart;
  logic              w_valid;
  logic              w_accept;
  logic              w_idxWrap;
  logic              w_lastBeat;
  logic              w_finish;
  logic [ADDR_W-1:0] w_ptr [N_SRC];
  logic [ADDR_W-1:0] w_curPtr;

  assign w_start     = (r_state == RESI_IDLE) & rd_req & cfg_resi_mode & (cfg_loop_num != '0);
  assign w_zeroStart = (r_state == RESI_IDLE) & rd_req & cfg_resi_mode & (cfg_loop_num == '0);
  assign w_valid     = (r_state == RESI_RUN) & ~rd_abort;
  assign w_accept    = w_valid & out_ready;
  assign w_idxWrap   = ({1'b0, r_srcIdx} == (r_srcNum - (SRC_W+1)'(1)));
  assign w_lastBeat  = (r_state == RESI_RUN) & w_idxWrap & (r_iter == (r_loopNum - LOOP_W'(1)));
  assign w_finish    = (r_state == RESI_RUN) & (rd_abort | (w_accept & w_lastBeat));

  // Out-of-range source counts are folded into 1..N_SRC before latching.
  always_comb begin
    w_srcNumClamp = cfg_src_num;
    if (cfg_src_num == '0) begin
      w_srcNumClamp = (SRC_W+1)'(1);
    end else if (cfg_src_num > (SRC_W+1)'(N_SRC)) begin
      w_srcNumClamp = (SRC_W+1)'(N_SRC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESI_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RESI_IDLE: if (w_start) w_nextState = RESI_RUN;
      RESI_RUN:  if (w_finish) w_nextState = RESI_IDLE;
      default:   w_nextState = RESI_IDLE;
    endcase
  end

  // Configuration is captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_srcNum  <= '0;
      r_gap     <= '0;
      r_lastAdj <= '0;
      r_loopNum <= '0;
    end else if (w_start) begin
      r_srcNum  <= w_srcNumClamp;
      r_gap     <= cfg_addr_gap;
      r_lastAdj <= cfg_last_adj;
      r_loopNum <= cfg_loop_num;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_srcIdx <= '0;
      r_iter   <= '0;
    end else if (w_start || w_finish) begin
      r_srcIdx <= '0;
      r_iter   <= '0;
    end else if (w_accept) begin
      if (w_idxWrap) begin
        r_srcIdx <= '0;
        r_iter   <= r_iter + LOOP_W'(1);
      end else begin
        r_srcIdx <= r_srcIdx + SRC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_zeroStart | w_finish;
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_ptr
    idma_resi_src_ptr #(
      .ADDR_W (ADDR_W),
      .GAP_W  (GAP_W)
    ) u_ptr (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_start),
      .i_base  (cfg_base_addr[g*ADDR_W +: ADDR_W]),
      .i_inc   (w_accept & (r_srcIdx == SRC_W'(g))),
      .i_gap   (r_gap),
      .i_clear (w_finish),
      .o_ptr   (w_ptr[g])
    );
  end

  always_comb begin
    w_curPtr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_srcIdx == SRC_W'(i)) w_curPtr = w_ptr[i];
    end
  end

  // The final source of the final iteration carries the extra offset.
  always_comb begin
    out_valid  = w_valid;
    out_addr   = '0;
    out_src_id = '0;
    out_last   = 1'b0;
    busy       = (r_state == RESI_RUN);
    done       = r_done;
    if (r_state == RESI_RUN) begin
      out_addr   = w_curPtr + (w_lastBeat ? ADDR_W'(r_lastAdj) : '0);
      out_src_id = r_srcIdx;
      out_last   = w_lastBeat;
    end
  end

endmodule

// File: tb/tb_idma_rd_sync_resi_raddr_gen_nsrc.sv
// Scoreboard bench: expected beats come from a plain arithmetic model and are
// consumed by a negedge monitor whenever the DUT hands over an address.
module tb_idma_rd_sync_resi_raddr_gen_nsrc;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int GW = 16;
  localparam int LW = 16;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_resi_mode = 1'b0;
  logic [SW:0]    cfg_src_num = '0;
  logic [NS*AW-1:0] cfg_base_addr = '0;
  logic [GW-1:0]  cfg_addr_gap = '0;
  logic [LW-1:0]  cfg_loop_num = '0;
  logic [GW-1:0]  cfg_last_adj = '0;
  logic           rd_req = 1'b0;
  logic           rd_abort = 1'b0;
  logic           out_ready = 1'b1;
  logic           out_valid;
  logic [AW-1:0]  out_addr;
  logic [SW-1:0]  out_src_id;
  logic           out_last;
  logic           busy;
  logic           done;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] src;
    logic          last;
  } beat_t;

  beat_t expQ[$];
  beat_t popBeat;
  beat_t stallBeat;
  logic  stallPrev = 1'b0;
  int    errors = 0;
  int    checks = 0;
  int    negCount = 0;
  int    expDoneNeg = -1;
  int    accCount = 0;
  int    readyMode = 0;

  idma_rd_sync_resi_raddr_gen_nsrc #(
    .NUM_SRC (NS),
    .ADDR_W  (AW),
    .GAP_W   (GW),
    .LOOP_W  (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_resi_mode (cfg_resi_mode),
    .cfg_src_num   (cfg_src_num),
    .cfg_base_addr (cfg_base_addr),
    .cfg_addr_gap  (cfg_addr_gap),
    .cfg_loop_num  (cfg_loop_num),
    .cfg_last_adj  (cfg_last_adj),
    .rd_req        (rd_req),
    .rd_abort      (rd_abort),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_addr      (out_addr),
    .out_src_id    (out_src_id),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops one expected beat per handshake and polices the done pulse.
  always @(negedge clk) begin
    negCount++;
    if (done === 1'b1 || negCount == expDoneNeg) begin
      checkOutput("donePulse", {63'b0, done}, {63'b0, (negCount == expDoneNeg)});
      if (negCount == expDoneNeg) checkOutput("busyAtDone", {63'b0, busy}, 64'd0);
    end
    if (!rst && out_valid === 1'b1) begin
      if (stallPrev) begin
        checkOutput("stallStable", {31'b0, out_addr, out_src_id, out_last},
                    {31'b0, stallBeat.addr, stallBeat.src, stallBeat.last});
      end
      if (out_ready) begin
        stallPrev = 1'b0;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedBeat: got addr 0x%0h src %0d, expected no beat at %0t",
                   out_addr, out_src_id, $time);
        end else begin
          popBeat = expQ.pop_front();
          accCount++;
          checkOutput("beatAddr", {32'b0, out_addr}, {32'b0, popBeat.addr});
          checkOutput("beatSrc", {62'b0, out_src_id}, {62'b0, popBeat.src});
          checkOutput("beatLast", {63'b0, out_last}, {63'b0, popBeat.last});
          if (popBeat.last) expDoneNeg = negCount + 1;
        end
      end else begin
        stallPrev = 1'b1;
        stallBeat = '{addr: out_addr, src: out_src_id, last: out_last};
      end
    end else begin
      stallPrev = 1'b0;
    end
  end

  // Model: address = base[s] + iter*gap, plus adj on the very last beat.
  task automatic applyStimulus(input int n, input logic [NS*AW-1:0] bases, input logic [GW-1:0] gap,
                               input int loops, input logic [GW-1:0] adj, input logic mode);
    int eff;
    beat_t b;
    beat_t first;
    logic [AW-1:0] a;
    eff = (n == 0) ? 1 : ((n > NS) ? NS : n);
    first = '0;
    cfg_resi_mode = mode;
    cfg_src_num   = 3'(n);
    cfg_base_addr = bases;
    cfg_addr_gap  = gap;
    cfg_loop_num  = LW'(loops);
    cfg_last_adj  = adj;
    rd_req = 1'b1;
    if (mode && loops > 0) begin
      for (int it = 0; it < loops; it++) begin
        for (int s = 0; s < eff; s++) begin
          a = bases[s*AW +: AW] + (32'(it) * 32'(gap));
          b.last = (it == loops - 1) && (s == eff - 1);
          if (b.last) a = a + 32'(adj);
          b.addr = a;
          b.src  = SW'(s);
          if (it == 0 && s == 0) first = b;
          expQ.push_back(b);
        end
      end
    end else if (mode) begin
      expDoneNeg = negCount + 2;
    end
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    cfg_resi_mode = 1'($urandom_range(0, 1));
    cfg_src_num   = 3'($urandom_range(0, 7));
    cfg_base_addr = {$urandom, $urandom, $urandom, $urandom};
    cfg_addr_gap  = GW'($urandom);
    cfg_loop_num  = LW'($urandom);
    cfg_last_adj  = GW'($urandom);
    if (mode && loops > 0) begin
      checkOutput("latencyValid", {63'b0, out_valid}, 64'd1);
      checkOutput("latencyAddr", {32'b0, out_addr}, {32'b0, first.addr});
    end
  endtask

  task automatic waitIdle(input int budget);
    int k;
    k = 0;
    while ((expQ.size() != 0 || busy) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL idleTimeout: got %0d beats outstanding, expected 0", expQ.size());
      expQ.delete();
      expDoneNeg = -1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    logic [NS*AW-1:0] bases;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstValid", {63'b0, out_valid}, 64'd0);
    checkOutput("rstAddr", {32'b0, out_addr}, 64'd0);
    checkOutput("rstSrc", {62'b0, out_src_id}, 64'd0);
    checkOutput("rstLast", {63'b0, out_last}, 64'd0);
    checkOutput("rstBusy", {63'b0, busy}, 64'd0);
    checkOutput("rstDone", {63'b0, done}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    readyMode = 0;
    applyStimulus(2, {64'h0, 32'h0000_8000, 32'h0000_1000}, 16'h40, 3, 16'h1, 1'b1);
    waitIdle(200);

    readyMode = 1;
    applyStimulus(3, {32'h0, 32'h200, 32'h100, 32'h0}, 16'h10, 2, 16'h0, 1'b1);
    waitIdle(200);

    readyMode = 0;
    applyStimulus(2, {64'h0, 32'h0000_8000, 32'h0000_1000}, 16'h40, 0, 16'h1, 1'b1);
    @(negedge clk);
    checkOutput("zeroLoopBusy", {63'b0, busy}, 64'd0);
    waitIdle(50);

    applyStimulus(2, {64'h0, 32'h0000_8000, 32'h0000_1000}, 16'h40, 3, 16'h1, 1'b0);
    waitIdle(50);

    // Abort after the third beat of a 2-source, 4-iteration sequence, then restart.
    bases = {64'h0, 32'h0000_5000, 32'h0000_4000};
    accCount = 0;
    applyStimulus(2, bases, 16'h20, 4, 16'h3, 1'b1);
    k = 0;
    while (accCount < 3 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL abortWait: got %0d beats, expected 3", accCount);
    end
    rd_abort = 1'b1;
    expQ.delete();
    expDoneNeg = negCount + 2;
    @(posedge clk);
    #1;
    rd_abort = 1'b0;
    @(negedge clk);
    checkOutput("abortBusy", {63'b0, busy}, 64'd0);
    checkOutput("abortValid", {63'b0, out_valid}, 64'd0);
    waitIdle(50);
    applyStimulus(2, bases, 16'h20, 4, 16'h3, 1'b1);
    waitIdle(200);

    applyStimulus(1, {96'h0, 32'hFFFF_FFC0}, 16'h40, 2, 16'h0, 1'b1);
    waitIdle(100);

    applyStimulus(0, {32'h0, 32'h0, 32'h0, 32'h0000_0700}, 16'h8, 3, 16'h2, 1'b1);
    waitIdle(100);
    readyMode = 2;
    applyStimulus(7, {32'h4000, 32'h3000, 32'h2000, 32'h1000}, 16'h4, 2, 16'h5, 1'b1);
    waitIdle(200);

    // A second request while busy must not disturb the running sequence.
    readyMode = 0;
    applyStimulus(2, {64'h0, 32'h0000_A000, 32'h0000_9000}, 16'h100, 4, 16'h7, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    cfg_resi_mode = 1'b1;
    cfg_loop_num  = 16'd5;
    cfg_base_addr = {$urandom, $urandom, $urandom, $urandom};
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    waitIdle(200);

    readyMode = 2;
    applyStimulus(3, {32'h0, 32'h3_0000, 32'h2_0000, 32'h1_0000}, 16'h40, 5, 16'h1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    expQ.delete();
    expDoneNeg = -1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstValid", {63'b0, out_valid}, 64'd0);
    checkOutput("midRstBusy", {63'b0, busy}, 64'd0);
    waitIdle(50);

    for (int r = 0; r < 25; r++) begin
      readyMode = $urandom_range(0, 2);
      applyStimulus($urandom_range(0, 7), {$urandom, $urandom, $urandom, $urandom}, GW'($urandom),
                    $urandom_range(0, 5), GW'($urandom), 1'($urandom_range(0, 7) != 0));
      waitIdle(500);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
